pipe_hazard_ctrl: RTL

- Central stall/flush scheduler for the 5-stage pipeline. It drives the stall and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- It resolves four hazard sources:
  - load-use data hazards;
  - taken branches and jumps;
  - multi-cycle EX operations such as the divider;
  - data-memory wait states.
- It uses a small FSM with a busy watchdog, and applies one fixed priority to all of these sources.

---
 rtl/pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush scheduler for the 5-stage pipeline. Resolves load-use
//   hazards, taken branches/jumps, multi-cycle EX operations (with a busy
//   watchdog) and data-memory wait states under one fixed priority:
//   memory wait > EX busy > taken branch > load-use.
//
// Parameters
//   BUSY_MAX    : EX_BUSY cycles allowed before the watchdog aborts the phase
//   BUSY_CNT_W  : busy counter width, 2**BUSY_CNT_W must exceed BUSY_MAX
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   id_reg_op{1,2}_rd_en/_addr   : source operands read by the ID stage
//   id_ex_isload, ex_wr_bck_en,
//   ex_wr_reg_addr               : destination info of the instruction in EX
//   ex_branch_taken              : EX resolved a taken branch or jump
//   ex_busy_req / ex_busy_done   : multi-cycle EX operation start / result valid
//   mem_req / mem_ready          : MEM access in flight / access completed
//   stall_* / flush_*            : hold / bubble controls for PC and pipe regs
//   busy_timeout                 : one-cycle registered pulse when watchdog fires
//
// Optional feature (macro PIPE_CTRL_PERF_CNT_EN)
//   perf_stall_cycles : cycles with stall_pc = 1 (wraps mod 2**32)
//   perf_flush_events : cycles with flush_if_id = 1 (wraps mod 2**32)

module pipe_hazard_ctrl #(
    parameter int unsigned BUSY_MAX   = 64,
    parameter int unsigned BUSY_CNT_W = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_reg_op1_rd_en,
    input  logic       id_reg_op2_rd_en,
    input  logic [4:0] id_reg_op1_rd_addr,
    input  logic [4:0] id_reg_op2_rd_addr,
    input  logic       id_ex_isload,
    input  logic       ex_wr_bck_en,
    input  logic [4:0] ex_wr_reg_addr,
    input  logic       ex_branch_taken,
    input  logic       ex_busy_req,
    input  logic       ex_busy_done,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       flush_if_id,
    output logic       stall_id_ex,
    output logic       flush_id_ex,
    output logic       stall_ex_mem,
    output logic       flush_ex_mem,
    output logic       flush_mem_wb,
    output logic       busy_timeout
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    localparam logic [BUSY_CNT_W-1:0] BUSY_MAX_C = BUSY_CNT_W'(BUSY_MAX);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EX_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Output patterns; selected first, decoded onto the port bits afterwards.
    typedef enum logic [2:0] {
        PAT_NONE,
        PAT_MEM,
        PAT_BUSY,
        PAT_BRANCH,
        PAT_LU
    } pattern_t;

    state_t                state, state_nxt;
    logic [BUSY_CNT_W-1:0] busy_cnt, busy_cnt_nxt;
    logic                  timeout_nxt;
    pattern_t              pat;
    logic                  lu, mw;

    // x0 is never a real producer, so it never creates a load-use stall.
    assign lu = id_ex_isload & ex_wr_bck_en & (ex_wr_reg_addr != 5'd0) &
                ((id_reg_op1_rd_en & (id_reg_op1_rd_addr == ex_wr_reg_addr)) |
                 (id_reg_op2_rd_en & (id_reg_op2_rd_addr == ex_wr_reg_addr)));

    assign mw = mem_req & ~mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            busy_cnt     <= '0;
            busy_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy_cnt     <= busy_cnt_nxt;
            busy_timeout <= timeout_nxt;
        end
    end

    // RUN and MEM_WAIT share one decode: MEM_WAIT only persists while mw
    // holds, and its mem_ready cycle is evaluated exactly like RUN.
    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        timeout_nxt  = 1'b0;
        pat          = PAT_NONE;
        unique case (state)
            EX_BUSY: begin
                if (mw) begin
                    pat          = PAT_MEM;
                    state_nxt    = MEM_WAIT;
                    busy_cnt_nxt = '0;
                end else if (ex_busy_done) begin
                    state_nxt = RUN;
                end else begin
                    pat = PAT_BUSY;
                    if (busy_cnt == BUSY_MAX_C) begin
                        // Counter holds at the limit rather than wrapping.
                        timeout_nxt = 1'b1;
                        state_nxt   = RUN;
                    end else begin
                        busy_cnt_nxt = busy_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (mw) begin
                    pat       = PAT_MEM;
                    state_nxt = MEM_WAIT;
                end else if (ex_busy_req) begin
                    pat          = PAT_BUSY;
                    state_nxt    = EX_BUSY;
                    busy_cnt_nxt = BUSY_CNT_W'(1);
                end else if (ex_branch_taken) begin
                    pat       = PAT_BRANCH;
                    state_nxt = RUN;
                end else if (lu) begin
                    pat       = PAT_LU;
                    state_nxt = RUN;
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    // Pipeline registers reset themselves, so every control is quiet in reset.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        if (!rst) begin
            unique case (pat)
                PAT_MEM: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                    flush_mem_wb = 1'b1;
                end
                PAT_BUSY: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end
                PAT_BRANCH: begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                PAT_LU: begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_pc};
            perf_flush_events <= perf_flush_events + {31'd0, flush_if_id};
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
